// File: rtl/bus_test_sequencer_if.sv
// Signal bundle between bus_test_sequencer and the surrounding dual-bus demo.
// The sequencer takes the master modport; the demo side (or a bench) takes the slave modport.
interface bus_test_sequencer_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 btn_raw;
    logic                 mode_sw;
    logic                 ready_in;
    logic                 trig_out;
    logic                 start_out;
    logic                 mode_out;
    logic                 busy;
    logic [CNT_WIDTH-1:0] done_cnt;
    logic                 timeout_flag;

    modport master (
        input  btn_raw, mode_sw, ready_in,
        output trig_out, start_out, mode_out, busy, done_cnt, timeout_flag
    );

    modport slave (
        output btn_raw, mode_sw, ready_in,
        input  trig_out, start_out, mode_out, busy, done_cnt, timeout_flag
    );
endinterface

// File: rtl/bus_test_sequencer.sv
// Button-driven sequencer: debounced press -> Bus A trigger pulse -> Bus B start/ready handshake.
// Optional feature macro: SEQ_AUTO_REPEAT_EN (re-issue while the button stays held).
module bus_test_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TRIG_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES  = 50000000,
    parameter int CNT_WIDTH       = 8,
    parameter int GAP_CYCLES      = 1000000
) (
    input logic                  clk,
    input logic                  btn_reset,
    bus_test_sequencer_if.master bus
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TR_W = $clog2(TRIG_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TRIG    = 3'd1,
        S_START   = 3'd2,
        S_BUSY    = 3'd3,
        S_DONE    = 3'd4,
        S_TIMEOUT = 3'd5
    } state_t;

    state_t state_r, next_state;

    logic [1:0]           btn_sync_r, mode_sync_r, ready_sync_r;
    logic                 btn_s, mode_s, ready_s;
    logic                 db_last_r, db_level_r, db_prev_r;
    logic [DB_W-1:0]      db_cnt_r;
    logic                 press_s, reissue_s, accept_s, to_hit_s;
    logic [TR_W-1:0]      trig_cnt_r;
    logic [TO_W-1:0]      to_cnt_r;
    logic                 trig_r, start_r, mode_r, busy_r, timeout_r;
    logic [CNT_WIDTH-1:0] done_r;

    assign btn_s   = btn_sync_r[1];
    assign mode_s  = mode_sync_r[1];
    assign ready_s = ready_sync_r[1];

    // Two-flop synchronizers for all asynchronous inputs
    always_ff @(posedge clk or posedge btn_reset) begin
        if (btn_reset) begin
            btn_sync_r   <= 2'b00;
            mode_sync_r  <= 2'b00;
            ready_sync_r <= 2'b00;
        end else begin
            btn_sync_r   <= {btn_sync_r[0], bus.btn_raw};
            mode_sync_r  <= {mode_sync_r[0], bus.mode_sw};
            ready_sync_r <= {ready_sync_r[0], bus.ready_in};
        end
    end

    // Debouncer: any change of the synced level restarts the stability count
    always_ff @(posedge clk or posedge btn_reset) begin
        if (btn_reset) begin
            db_last_r  <= 1'b0;
            db_level_r <= 1'b0;
            db_prev_r  <= 1'b0;
            db_cnt_r   <= '0;
        end else begin
            db_prev_r <= db_level_r;
            if (btn_s != db_last_r) begin
                db_last_r <= btn_s;
                db_cnt_r  <= '0;
            end else if (db_cnt_r == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_level_r <= db_last_r;
            end else begin
                db_cnt_r <= db_cnt_r + DB_W'(1);
            end
        end
    end

    assign press_s  = db_level_r & ~db_prev_r;
    assign to_hit_s = (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));

`ifdef SEQ_AUTO_REPEAT_EN
    localparam int GP_W = $clog2(GAP_CYCLES + 1);
    logic            rpt_armed_r;
    logic [GP_W-1:0] gap_cnt_r;

    // The gap is measured from the S_DONE cycle, so the counter is preloaded with 1 there
    always_ff @(posedge clk or posedge btn_reset) begin
        if (btn_reset) begin
            rpt_armed_r <= 1'b0;
            gap_cnt_r   <= '0;
        end else if (state_r == S_DONE) begin
            rpt_armed_r <= db_level_r;
            gap_cnt_r   <= GP_W'(1);
        end else if ((state_r == S_IDLE) && rpt_armed_r) begin
            if (!db_level_r || accept_s) begin
                rpt_armed_r <= 1'b0;
            end else if (gap_cnt_r < GP_W'(GAP_CYCLES - 1)) begin
                gap_cnt_r <= gap_cnt_r + GP_W'(1);
            end
        end else begin
            rpt_armed_r <= 1'b0;
        end
    end

    assign reissue_s = rpt_armed_r && db_level_r && (gap_cnt_r >= GP_W'(GAP_CYCLES - 1));
`else
    // No re-issue without auto-repeat; the comparison only keeps GAP_CYCLES referenced.
    assign reissue_s = (GAP_CYCLES < 0);
`endif

    // FSM state register
    always_ff @(posedge clk or posedge btn_reset) begin
        if (btn_reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state;
        end
    end

    // Next-state logic; the exit condition is tested before the timeout so it wins a tie
    always_comb begin
        next_state = state_r;
        accept_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (press_s || reissue_s) begin
                    next_state = S_TRIG;
                    accept_s   = 1'b1;
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_TRIG: begin
                if (trig_cnt_r == TR_W'(TRIG_CYCLES - 1)) begin
                    next_state = S_START;
                end else begin
                    next_state = S_TRIG;
                end
            end
            S_START: begin
                if (!ready_s) begin
                    next_state = S_BUSY;
                end else if (to_hit_s) begin
                    next_state = S_TIMEOUT;
                end else begin
                    next_state = S_START;
                end
            end
            S_BUSY: begin
                if (ready_s) begin
                    next_state = S_DONE;
                end else if (to_hit_s) begin
                    next_state = S_TIMEOUT;
                end else begin
                    next_state = S_BUSY;
                end
            end
            S_DONE:    next_state = S_IDLE;
            S_TIMEOUT: next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // Trigger-width and handshake-timeout counters
    always_ff @(posedge clk or posedge btn_reset) begin
        if (btn_reset) begin
            trig_cnt_r <= '0;
            to_cnt_r   <= '0;
        end else begin
            trig_cnt_r <= (state_r == S_TRIG) ? trig_cnt_r + TR_W'(1) : '0;
            to_cnt_r   <= ((state_r == S_START) || (state_r == S_BUSY)) ? to_cnt_r + TO_W'(1) : '0;
        end
    end

    // Outputs are registered from the next state so they line up with the state register
    always_ff @(posedge clk or posedge btn_reset) begin
        if (btn_reset) begin
            trig_r    <= 1'b0;
            start_r   <= 1'b0;
            busy_r    <= 1'b0;
            mode_r    <= 1'b0;
            timeout_r <= 1'b0;
            done_r    <= '0;
        end else begin
            trig_r  <= (next_state == S_TRIG);
            start_r <= (next_state == S_START);
            busy_r  <= (next_state != S_IDLE);
            if (accept_s) begin
                mode_r <= mode_s;
            end
            if (next_state == S_TIMEOUT) begin
                timeout_r <= 1'b1;
            end else if (accept_s) begin
                timeout_r <= 1'b0;
            end
            if (state_r == S_DONE) begin
                done_r <= done_r + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.trig_out     = trig_r;
    assign bus.start_out    = start_r;
    assign bus.busy         = busy_r;
    assign bus.mode_out     = mode_r;
    assign bus.timeout_flag = timeout_r;
    assign bus.done_cnt     = done_r;
endmodule

// File: tb/tb_bus_test_sequencer.sv
// Directed, scoreboard-based bench for bus_test_sequencer (small debounce/trigger/timeout values).
module tb_bus_test_sequencer;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic btn_reset;
    always #5 clk = ~clk;

    bus_test_sequencer_if #(.CNT_WIDTH(CW)) bus_if ();

    bus_test_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .TRIG_CYCLES    (3),
        .TIMEOUT_CYCLES (20),
        .CNT_WIDTH      (CW),
        .GAP_CYCLES     (10)
    ) dut (
        .clk      (clk),
        .btn_reset(btn_reset),
        .bus      (bus_if)
    );

    typedef struct packed {
        logic          mode;
        logic [CW-1:0] done;
        logic          tflag;
    } exp_t;

    exp_t          sb_q[$];
    int            n_cmp = 0;
    int            n_mis = 0;
    int            btn_hold = 0;
    logic [CW-1:0] exp_done = '0;

    int   trig_rises = 0;
    int   trig_len = 0;
    int   trig_last_len = 0;
    logic trig_prev = 1'b0;

    // Trigger pulse monitor: counts rising edges and records the width of the last pulse
    always @(negedge clk) begin
        if (bus_if.trig_out && !trig_prev) begin
            trig_rises <= trig_rises + 1;
            trig_len   <= 1;
        end else if (bus_if.trig_out) begin
            trig_len <= trig_len + 1;
        end else if (trig_prev) begin
            trig_last_len <= trig_len;
        end
        trig_prev <= bus_if.trig_out;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One cycle; a pending press is released after its hold time
    task automatic step();
        @(negedge clk);
        if (btn_hold > 0) begin
            btn_hold--;
            if (btn_hold == 0) bus_if.btn_raw = 1'b0;
        end
    endtask

    task automatic push_exp(input logic m, input logic tflag, input bit completes);
        exp_t e;
        if (completes) exp_done = exp_done + CW'(1);
        e.mode  = m;
        e.done  = exp_done;
        e.tflag = tflag;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        e = sb_q.pop_front();
        check({tag, "_mode"},  32'(bus_if.mode_out),     32'(e.mode));
        check({tag, "_done"},  32'(bus_if.done_cnt),     32'(e.done));
        check({tag, "_tflag"}, 32'(bus_if.timeout_flag), 32'(e.tflag));
        check({tag, "_start"}, 32'(bus_if.start_out),    32'd0);
    endtask

    task automatic wait_busy_low(input string tag);
        int w = 0;
        while (bus_if.busy && w < 60) begin
            step();
            w++;
        end
        check({tag, "_busy_low"}, 32'(bus_if.busy), 32'd0);
    endtask

    task automatic wait_start(input string tag);
        int w = 0;
        while (!bus_if.start_out && w < 60) begin
            step();
            w++;
        end
        check({tag, "_start_seen"}, 32'(bus_if.start_out), 32'd1);
    endtask

    // mode_resp: 0 = ready low before press, 1 = normal handshake, 2 = no response
    task automatic do_txn(input string tag, input logic m, input bit glitch, input int mode_resp);
        int r0, w, slen;
        r0 = trig_rises;
        bus_if.mode_sw = m;
        if (mode_resp == 0) bus_if.ready_in = 1'b0;
        if (glitch) begin
            bus_if.btn_raw = 1'b1;
            repeat (2) step();
            bus_if.btn_raw = 1'b0;
            repeat (3) step();
        end
        push_exp(m, (mode_resp == 2), (mode_resp != 2));
        bus_if.btn_raw = 1'b1;
        btn_hold = 10;
        wait_start(tag);
        check({tag, "_mode_hold"}, 32'(bus_if.mode_out), 32'(m));
        if (mode_resp == 0) begin
            step();
            check({tag, "_start_1cyc"}, 32'(bus_if.start_out), 32'd0);
            check({tag, "_busy_mid"},   32'(bus_if.busy),      32'd1);
            repeat (6) step();
            bus_if.ready_in = 1'b1;
        end else if (mode_resp == 2) begin
            slen = 1;
            while (bus_if.start_out && slen < 40) begin
                step();
                if (bus_if.start_out) slen++;
            end
            check({tag, "_start_len"}, 32'(slen),                20);
            check({tag, "_tflag_now"}, 32'(bus_if.timeout_flag), 32'd1);
        end else begin
            repeat (5) step();
            bus_if.ready_in = 1'b0;
            w = 0;
            while (bus_if.start_out && w < 10) begin
                step();
                w++;
            end
            // two synchronizer stages plus the state transition
            check({tag, "_drop_lat"}, 32'(w),                3);
            check({tag, "_busy_mid"}, 32'(bus_if.busy),      32'd1);
            repeat (8) step();
            bus_if.ready_in = 1'b1;
        end
        wait_busy_low(tag);
        pop_check(tag);
        check({tag, "_one_trig"}, 32'(trig_rises - r0), 32'd1);
        while (btn_hold > 0) step();
        repeat (10) step();
        check({tag, "_trig_len"}, 32'(trig_last_len), 32'd3);
    endtask

    initial begin
        int r0, w;
        btn_reset      = 1'b1;
        bus_if.btn_raw  = 1'b0;
        bus_if.mode_sw  = 1'b0;
        bus_if.ready_in = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_trig",  32'(bus_if.trig_out),     32'd0);
        check("rst_start", 32'(bus_if.start_out),    32'd0);
        check("rst_mode",  32'(bus_if.mode_out),     32'd0);
        check("rst_busy",  32'(bus_if.busy),         32'd0);
        check("rst_done",  32'(bus_if.done_cnt),     32'd0);
        check("rst_tflag", 32'(bus_if.timeout_flag), 32'd0);
        btn_reset = 1'b0;
        repeat (5) step();

        do_txn("glitch", 1'b1, 1'b1, 1);
        do_txn("hs_mode0", 1'b0, 1'b0, 1);
        do_txn("timeout", 1'b1, 1'b0, 2);
        do_txn("recover", 1'b1, 1'b0, 1);

        for (int i = 0; i < 13; i++) do_txn("wrap_fill", i[0], 1'b0, 0);
        check("wrap_zero", 32'(bus_if.done_cnt), 32'd0);
        do_txn("wrap_one", 1'b0, 1'b0, 0);
        check("wrap_one_val", 32'(bus_if.done_cnt), 32'd1);

        // Reset in the middle of the trigger pulse
        bus_if.btn_raw = 1'b1;
        btn_hold = 10;
        w = 0;
        while (!bus_if.trig_out && w < 40) begin
            step();
            w++;
        end
        check("pre_rst_trig", 32'(bus_if.trig_out), 32'd1);
        #1 btn_reset = 1'b1;
        #1;
        check("async_trig", 32'(bus_if.trig_out), 32'd0);
        check("async_busy", 32'(bus_if.busy),     32'd0);
        check("async_done", 32'(bus_if.done_cnt), 32'd0);
        bus_if.btn_raw = 1'b0;
        btn_hold = 0;
        exp_done = '0;
        repeat (4) @(negedge clk);
        btn_reset = 1'b0;
        r0 = trig_rises;
        repeat (12) step();
        check("post_rst_busy",  32'(bus_if.busy),       32'd0);
        check("post_rst_done",  32'(bus_if.done_cnt),   32'd0);
        check("post_rst_quiet", 32'(trig_rises - r0),   32'd0);

`ifdef SEQ_AUTO_REPEAT_EN
        // Button held through two completions, released during the second gap
        bus_if.mode_sw  = 1'b1;
        bus_if.ready_in = 1'b0;
        push_exp(1'b1, 1'b0, 1'b1);
        bus_if.btn_raw = 1'b1;
        wait_start("rpt1");
        repeat (4) step();
        bus_if.ready_in = 1'b1;
        wait_busy_low("rpt1");
        pop_check("rpt1");
        bus_if.ready_in = 1'b0;
        push_exp(1'b1, 1'b0, 1'b1);
        w = 0;
        while (!bus_if.trig_out && w < 30) begin
            step();
            w++;
        end
        // first idle negedge is one cycle after S_DONE, so 9 more makes 10 from S_DONE
        check("rpt_gap", 32'(w), 32'd9);
        wait_start("rpt2");
        repeat (4) step();
        bus_if.ready_in = 1'b1;
        wait_busy_low("rpt2");
        pop_check("rpt2");
        bus_if.btn_raw = 1'b0;
        r0 = trig_rises;
        repeat (30) step();
        check("rpt_cancel", 32'(trig_rises - r0), 32'd0);
        check("rpt_idle",   32'(bus_if.busy),     32'd0);
`endif

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
